// File: rtl/cla_8bit_adder.sv
// Registered 8-bit carry-lookahead adder: {c8, sum} = a + b + c0, with group
// propagate/generate for cascading. Bit cells form p/g/s; every carry is a
// flat sum of products over p/g/c0, so no carry ripples from bit to bit.
module cla_8bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic       out_valid,
  output logic [7:0] sum,
  output logic       c8,
  output logic       pg,
  output logic       gg
);

  localparam int unsigned W = 8;

  logic [W-1:0] p;       // bit propagate
  logic [W-1:0] g;       // bit generate
  logic [W:0]   c;       // carries, c[0] = c0
  logic [W:0]   gc;      // carries assuming c0 = 0
  logic [W-1:0] s_c;     // combinational sum
  logic         pg_c;
  logic         gg_c;

  // Per-bit full-adder cells: propagate and generate.
  always_comb begin
    p = a ^ b;
    g = a & b;
  end

  // Flat lookahead network: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0.
  // gc[] is the same network with the c0 product term dropped.
  always_comb begin
    logic gen_term;
    logic gen_or;
    logic cin_term;
    c  = '0;
    gc = '0;
    gen_term = 1'b0;
    gen_or   = 1'b0;
    cin_term = 1'b0;
    c[0] = c0;
    for (int i = 0; i < int'(W); i++) begin
      gen_or = 1'b0;
      for (int j = 0; j <= i; j++) begin
        gen_term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          gen_term = gen_term & p[k];
        end
        gen_or = gen_or | gen_term;
      end
      cin_term = c0;
      for (int k = 0; k <= i; k++) begin
        cin_term = cin_term & p[k];
      end
      gc[i+1] = gen_or;
      c[i+1]  = gen_or | cin_term;
    end
  end

  // Sum bits and group propagate/generate.
  always_comb begin
    s_c  = p ^ c[W-1:0];
    pg_c = &p;
    gg_c = gc[W];
  end

  // Output register: load on valid, hold otherwise; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c8        <= 1'b0;
      pg        <= 1'b0;
      gg        <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      sum       <= s_c;
      c8        <= c[W];
      pg        <= pg_c;
      gg        <= gg_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_8bit_adder.sv
// Self-checking bench for cla_8bit_adder: directed literal cases plus
// randomized traffic compared every cycle against an arithmetic model.
module tb_cla_8bit_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       c0;
  logic       out_valid;
  logic [7:0] sum;
  logic       c8;
  logic       pg;
  logic       gg;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the outputs must show after the most recent edge.
  logic       exp_valid = 1'b0;
  logic [7:0] exp_sum   = '0;
  logic       exp_c8    = 1'b0;
  logic       exp_pg    = 1'b0;
  logic       exp_gg    = 1'b0;
  logic       exp_c0    = 1'b0;
  bit         chk_en    = 1'b0;

  cla_8bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .out_valid (out_valid),
    .sum       (sum),
    .c8        (c8),
    .pg        (pg),
    .gg        (gg)
  );

  always #5 clk = ~clk;

  // Arithmetic reference model, sampled on the same edge as the DUT.
  always @(posedge clk) begin
    logic [8:0] total;
    if (rst) begin
      exp_valid = 1'b0;
      exp_sum   = '0;
      exp_c8    = 1'b0;
      exp_pg    = 1'b0;
      exp_gg    = 1'b0;
      chk_en    = 1'b1;
    end else if (in_valid) begin
      total     = 9'(a) + 9'(b) + 9'(c0);
      exp_valid = 1'b1;
      exp_sum   = total[7:0];
      exp_c8    = total[8];
      exp_pg    = ((a ^ b) == 8'hFF);
      exp_gg    = ((9'(a) + 9'(b)) > 9'd255);
      exp_c0    = c0;
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (out_valid !== exp_valid || sum !== exp_sum || c8 !== exp_c8 ||
          pg !== exp_pg || gg !== exp_gg) begin
        n_fail++;
        $display("FAIL model t=%0t got v=%b sum=%h c8=%b pg=%b gg=%b exp v=%b sum=%h c8=%b pg=%b gg=%b",
                 $time, out_valid, sum, c8, pg, gg,
                 exp_valid, exp_sum, exp_c8, exp_pg, exp_gg);
      end
      if (exp_valid) begin
        n_checks++;
        if (c8 !== (gg | (pg & exp_c0))) begin
          n_fail++;
          $display("FAIL invariant t=%0t c8=%b gg=%b pg=%b c0=%b", $time, c8, gg, pg, exp_c0);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci);
    in_valid = v;
    a        = ai;
    b        = bi;
    c0       = ci;
  endtask

  // Hand-computed literal expectation on the current outputs.
  task automatic check_lit(input string name, input logic v, input logic [7:0] s,
                           input logic e8, input logic ep, input logic eg);
    n_checks++;
    if (out_valid !== v || sum !== s || c8 !== e8 || pg !== ep || gg !== eg) begin
      n_fail++;
      $display("FAIL %s got v=%b sum=%h c8=%b pg=%b gg=%b exp v=%b sum=%h c8=%b pg=%b gg=%b",
               name, out_valid, sum, c8, pg, gg, v, s, e8, ep, eg);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check_lit("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_lit("post_reset", 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 8'd30, 8'd100, 1'b0);
    @(negedge clk);
    check_lit("basic_add", 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 8'h7F, 8'h80, 1'b1);
    @(negedge clk);
    check_lit("prop_chain_c1", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 8'h80, 1'b0);
    @(negedge clk);
    check_lit("prop_chain_c0", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    check_lit("maximum", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hFE, 8'h00, 1'b0);
    @(negedge clk);
    check_lit("mult_upper", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    check_lit("stream0", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h80, 8'h80, 1'b0);
    @(negedge clk);
    check_lit("stream1", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h0F, 8'hF1, 1'b0);
    @(negedge clk);
    check_lit("stream2", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'hAA, 8'h33, 1'b1);
    @(negedge clk);
    check_lit("hold", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'h5C, 8'hE7, 1'b0);
    @(negedge clk);
    check_lit("hold_junk", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check_lit("zero_cin", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    // In-flight result discarded by reset.
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_lit("reset_inflight", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Randomized traffic; junk operands while invalid, rare resets.
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
